pixel_align_buffer: RTL
=======================

Name: pixel_align_buffer

Overview:
Parametrised successor to the homography sync controller. Pixels from the ColorTransform FIFO are stored in a circular in-flight buffer and their coordinates are forwarded to the Homography unit as queries. Each Homography result is paired, in order, with the oldest stored pixel to produce an aligned DVI/CCD pixel pair. Adds configurable depth and widths, backpressure, flush, overflow/underflow detection, and a coordinate-mismatch check with a counter.

Parameters:
DEPTH, 8, in-flight slots; power of two, 2..64
COORD_W, 10, x/y coordinate width
IN_CW, 8, input colour channel width (ColorTransform side)
R_W, 5, output red width
G_W, 6, output green width
B_W, 5, output blue width
ERR_CNT_W, 8, mismatch counter width (saturating)

Ports:
clk_25  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ColorTransform read strobe (pixel present)
in_x, in_y  in  COORD_W  pixel coordinates
in_r, in_g, in_b  in  IN_CW  pixel colour
in_ready  out  1  buffer can accept a pixel (combinational, = !full)
query_x, query_y  out  COORD_W  coordinates sent to Homography
start  out  1  one-cycle query strobe
ret_valid  in  1  Homography result strobe
ret_x, ret_y  in  COORD_W  coordinates echoed by Homography
ret_r  in  R_W  CCD red
ret_g  in  G_W  CCD green
ret_b  in  B_W  CCD blue
flush  in  1  synchronous: empty the buffer, keep sticky flags
clr_err  in  1  synchronous: clear sticky flags and counter
val  out  1  aligned output strobe
sync_x, sync_y  out  COORD_W  coordinates of the stored pixel
dvi_r, dvi_g, dvi_b  out  R_W/G_W/B_W  stored pixel colour, truncated to MSBs
ccd_r, ccd_g, ccd_b  out  R_W/G_W/B_W  Homography colour
level  out  log2(DEPTH)+1  occupancy
overflow, underflow, mismatch  out  1  sticky error flags
mismatch_cnt  out  ERR_CNT_W  saturating mismatch count

Behaviour:
- Reset: all outputs, pointers and level are 0. in_ready is 1 after reset.
- Push, when in_valid && !full:
  - Store {x, y, r[IN_CW-1 -: R_W], g[IN_CW-1 -: G_W], b[IN_CW-1 -: B_W]} at wr_ptr, then wr_ptr++.
  - Next cycle: query_x/query_y hold the new coordinates and start=1 for exactly that cycle.
  - Latency from in_valid to start is 1 cycle.
- Pop, when ret_valid && !empty:
  - Read the slot at rd_ptr, then rd_ptr++.
  - Next cycle: val=1 and the sync/dvi outputs come from the slot; ccd outputs come from ret_r/g/b.
  - Latency from ret_valid to val is 1 cycle.
  - Outputs hold their last values while val=0.
- Simultaneous push and pop: both happen. level is unchanged. Push into a full buffer with a same-cycle pop is still rejected, because in_ready is based on the current occupancy.
- Push when full: pixel dropped, no start, overflow set.
- ret_valid when empty: result discarded, val stays 0, underflow set.
- Coordinate check on each pop: if the stored x/y differ from ret_x/ret_y, mismatch is set and mismatch_cnt increments, saturating at all-ones. val still asserts and the data is still output.
- Pointers wrap modulo DEPTH. full = (level==DEPTH), empty = (level==0).
- flush has priority over push and pop that cycle:
  - Pointers and level go to 0.
  - start and val are 0 next cycle.
  - Sticky flags are kept.
- clr_err clears overflow, underflow, mismatch and mismatch_cnt. An error event in the same cycle wins, so the flag is set (counter value = 1).
- Reset mid-stream discards all in-flight entries immediately (asynchronous).

Decomposition:
- Package pixel_align_pkg holds:
  - default width constants
  - a pixel_entry struct {x, y, r, g, b}
  - a function computing the level width
- Natural sub-module: align_ring_buf. It is the DEPTH-entry circular storage with wr/rd pointers and level, plus full/empty/flush. The top level holds the query/output registers and the error logic.

Test Plan:
1. DEPTH=8. Push (3,4,rgb=FF,80,10), then ret_valid 5 cycles later with ret_x=3, ret_y=4 -> start pulses 1 cycle after push with query=(3,4). val 1 cycle after ret with dvi=(31,32,2) and sync=(3,4). mismatch=0.
2. Push 8 pixels back-to-back, then a 9th -> in_ready=0 after the 8th, level=8, 9th dropped, overflow=1. The 8 returns pop in order with wrap-around correct.
3. Continuous push+pop each cycle at level 3 -> level holds 3, val every cycle, outputs match FIFO order.
4. ret_valid with level=0 -> val=0, underflow=1. Then clr_err -> underflow=0.
5. Return ret_x=7 for a stored x=6, repeated 300 times with ERR_CNT_W=8 -> mismatch=1, mismatch_cnt saturates at 255.
6. Level 5, assert flush with a simultaneous push -> level=0 next cycle, no start, sticky flags unchanged. Then rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pixel_align_pkg.sv
// Shared constants, entry layout and helpers for the pixel alignment buffer.
package pixel_align_pkg;

  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_COORD_W   = 10;
  localparam int unsigned DEF_IN_CW     = 8;
  localparam int unsigned DEF_R_W       = 5;
  localparam int unsigned DEF_G_W       = 6;
  localparam int unsigned DEF_B_W       = 5;
  localparam int unsigned DEF_ERR_CNT_W = 8;

  // Layout of one in-flight slot at default widths; the ring stores the same
  // field order as a flat vector so non-default widths pack identically.
  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_R_W-1:0]     r;
    logic [DEF_G_W-1:0]     g;
    logic [DEF_B_W-1:0]     b;
  } pixel_entry_t;

  // Occupancy needs one extra bit so that a full ring (level == DEPTH) is representable.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/align_ring_buf.sv
// Circular in-flight storage: write/read pointers, occupancy, full/empty and flush.
module align_ring_buf import pixel_align_pkg::*; #(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = 36,
  localparam int unsigned LEVEL_W = level_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               do_push, do_pop;

  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem[rd_ptr_q];

  // Flush wins over any same-cycle push or pop.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end
  end

  // Pointer and occupancy state; reset discards all in-flight entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Slot storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pixel_align_buffer.sv
// Pairs Homography results, in order, with buffered ColorTransform pixels; tracks errors.
module pixel_align_buffer import pixel_align_pkg::*; #(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned COORD_W   = DEF_COORD_W,
  parameter int unsigned IN_CW     = DEF_IN_CW,
  parameter int unsigned R_W       = DEF_R_W,
  parameter int unsigned G_W       = DEF_G_W,
  parameter int unsigned B_W       = DEF_B_W,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W,
  localparam int unsigned LEVEL_W  = level_width(DEPTH)
) (
  input  logic                 clk_25,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [COORD_W-1:0]   in_x,
  input  logic [COORD_W-1:0]   in_y,
  input  logic [IN_CW-1:0]     in_r,
  input  logic [IN_CW-1:0]     in_g,
  input  logic [IN_CW-1:0]     in_b,
  output logic                 in_ready,
  output logic [COORD_W-1:0]   query_x,
  output logic [COORD_W-1:0]   query_y,
  output logic                 start,
  input  logic                 ret_valid,
  input  logic [COORD_W-1:0]   ret_x,
  input  logic [COORD_W-1:0]   ret_y,
  input  logic [R_W-1:0]       ret_r,
  input  logic [G_W-1:0]       ret_g,
  input  logic [B_W-1:0]       ret_b,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic                 val,
  output logic [COORD_W-1:0]   sync_x,
  output logic [COORD_W-1:0]   sync_y,
  output logic [R_W-1:0]       dvi_r,
  output logic [G_W-1:0]       dvi_g,
  output logic [B_W-1:0]       dvi_b,
  output logic [R_W-1:0]       ccd_r,
  output logic [G_W-1:0]       ccd_g,
  output logic [B_W-1:0]       ccd_b,
  output logic [LEVEL_W-1:0]   level,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] mismatch_cnt
);

  localparam int unsigned ENTRY_W = 2 * COORD_W + R_W + G_W + B_W;

  logic [ENTRY_W-1:0]   wr_entry, rd_entry;
  logic [COORD_W-1:0]   rd_x, rd_y;
  logic [R_W-1:0]       rd_r;
  logic [G_W-1:0]       rd_g;
  logic [B_W-1:0]       rd_b;
  logic                 full, empty;
  logic                 push_ok, pop_ok;
  logic                 ovf_evt, udf_evt, mm_evt;
  logic                 overflow_d, underflow_d, mismatch_d;
  logic [ERR_CNT_W-1:0] cnt_base, mismatch_cnt_d;

  // in_ready reflects current occupancy, so a full ring rejects even with a same-cycle pop.
  assign in_ready = !full;
  assign push_ok  = in_valid && !full && !flush;
  assign pop_ok   = ret_valid && !empty && !flush;
  assign ovf_evt  = in_valid && full && !flush;
  assign udf_evt  = ret_valid && empty && !flush;
  assign mm_evt   = pop_ok && ((rd_x != ret_x) || (rd_y != ret_y));

  // Colour is reduced to its MSBs before storage.
  assign wr_entry = {in_x, in_y, in_r[IN_CW-1 -: R_W], in_g[IN_CW-1 -: G_W],
                     in_b[IN_CW-1 -: B_W]};
  assign {rd_x, rd_y, rd_r, rd_g, rd_b} = rd_entry;

  align_ring_buf #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ring (
    .clk     (clk_25),
    .rst_n   (rst_n),
    .push    (push_ok),
    .pop     (pop_ok),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Sticky flag next state: a same-cycle error event overrides clr_err.
  always_comb begin
    overflow_d     = clr_err ? 1'b0 : overflow;
    underflow_d    = clr_err ? 1'b0 : underflow;
    mismatch_d     = clr_err ? 1'b0 : mismatch;
    cnt_base       = clr_err ? '0 : mismatch_cnt;
    mismatch_cnt_d = cnt_base;
    if (ovf_evt) overflow_d  = 1'b1;
    if (udf_evt) underflow_d = 1'b1;
    if (mm_evt) begin
      mismatch_d = 1'b1;
      if (cnt_base != {ERR_CNT_W{1'b1}}) mismatch_cnt_d = cnt_base + 1'b1;
    end
  end

  // Query strobe and coordinates for each accepted pixel.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      start   <= 1'b0;
      query_x <= '0;
      query_y <= '0;
    end else begin
      start <= push_ok;
      if (push_ok) begin
        query_x <= in_x;
        query_y <= in_y;
      end
    end
  end

  // Aligned output pair; data holds its last value while val is low.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      val    <= 1'b0;
      sync_x <= '0;
      sync_y <= '0;
      dvi_r  <= '0;
      dvi_g  <= '0;
      dvi_b  <= '0;
      ccd_r  <= '0;
      ccd_g  <= '0;
      ccd_b  <= '0;
    end else begin
      val <= pop_ok;
      if (pop_ok) begin
        sync_x <= rd_x;
        sync_y <= rd_y;
        dvi_r  <= rd_r;
        dvi_g  <= rd_g;
        dvi_b  <= rd_b;
        ccd_r  <= ret_r;
        ccd_g  <= ret_g;
        ccd_b  <= ret_b;
      end
    end
  end

  // Sticky error flags and saturating mismatch counter.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      overflow     <= overflow_d;
      underflow    <= underflow_d;
      mismatch     <= mismatch_d;
      mismatch_cnt <= mismatch_cnt_d;
    end
  end

endmodule
